// File: rtl/pwm_gen.sv
// ---------------------------------------------------------------------------
// pwm_gen -- PWM waveform generator with shadow-latched frequency/duty.
//
// Takes the 3-bit frequency code from the upstream frequency-select counter
// and a duty word, and produces a glitch-free PWM output plus a one-cycle
// period-start strobe. freq_sel and duty are sampled only when a run starts
// (LOAD) and at every period boundary, so input changes never truncate or
// stretch a period that is already running.
//
// Optional build macro: PWM_COMPL_EN
//   When defined, adds the complementary output pwm_n. pwm and pwm_n are
//   separated by DEAD_CYC clk cycles of dead time around every transition.
//
// Ports:
//   clk          in   1       system clock, rising edge
//   rst          in   1       asynchronous reset, active low
//   en           in   1       run request (level)
//   freq_sel     in   3       tick length = BASE_DIV << freq_sel clk cycles
//   duty         in   DUTY_W  high time in ticks per period
//   pwm          out  1       PWM output (registered)
//   pwm_n        out  1       complementary output (PWM_COMPL_EN only)
//   period_start out  1       one-clk pulse on the first cycle of a period
//   busy         out  1       high in LOAD, RUN and DRAIN
// ---------------------------------------------------------------------------
module pwm_gen #(
    parameter int unsigned BASE_DIV = 16,
    parameter int unsigned DUTY_W   = 4,
    parameter int unsigned DEAD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        freq_sel,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm,
`ifdef PWM_COMPL_EN
    output logic              pwm_n,
`endif
    output logic              period_start,
    output logic              busy
);

    // Wide enough for the longest tick (BASE_DIV << 7) without overflow.
    localparam int unsigned DIV_W = $clog2(BASE_DIV * 128);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [DIV_W:0]    tick_len;
    logic [DUTY_W-1:0] pwm_cnt, cnt_nxt;
    logic [2:0]        fsel_r, fsel_nxt;
    logic [DUTY_W-1:0] duty_r, duty_nxt;
    logic              tick;
    logic              pb;
    logic              run_nxt;
    logic              pwm_d;
    logic              ps_d;

    // -----------------------------------------------------------------------
    // Next-state / datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        cnt_nxt   = pwm_cnt;
        fsel_nxt  = fsel_r;
        duty_nxt  = duty_r;

        // One extra bit so BASE_DIV << 7 is represented before the -1.
        tick_len = (DIV_W + 1)'(BASE_DIV) << fsel_r;
        tick     = ((state == S_RUN) || (state == S_DRAIN)) &&
                   (div_cnt == DIV_W'(tick_len - 1'b1));
        pb       = tick && (pwm_cnt == '1);

        case (state)
            S_IDLE: begin
                div_nxt = '0;
                cnt_nxt = '0;
                if (en) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                div_nxt   = '0;
                cnt_nxt   = '0;
                fsel_nxt  = freq_sel;
                duty_nxt  = duty;
                state_nxt = S_RUN;
            end
            S_RUN, S_DRAIN: begin
                if (tick) begin
                    div_nxt = '0;
                    cnt_nxt = pwm_cnt + 1'b1;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
                if (pb) begin
                    fsel_nxt = freq_sel;
                    duty_nxt = duty;
                end
                if (state == S_RUN) begin
                    if (!en) state_nxt = S_DRAIN;
                end else begin
                    // Re-enable resumes without touching the counters; an
                    // un-revoked drain ends on the period boundary.
                    if (en)      state_nxt = S_RUN;
                    else if (pb) state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        run_nxt = (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
        // The output register is fed from next-cycle values so that pwm is
        // aligned with the cycle whose pwm_cnt it reflects.
        pwm_d   = run_nxt && (cnt_nxt < duty_nxt);
        ps_d    = (state == S_LOAD) || (pb && (state_nxt != S_IDLE));
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            div_cnt      <= '0;
            pwm_cnt      <= '0;
            fsel_r       <= '0;
            duty_r       <= '0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            div_cnt      <= div_nxt;
            pwm_cnt      <= cnt_nxt;
            fsel_r       <= fsel_nxt;
            duty_r       <= duty_nxt;
            period_start <= ps_d;
        end
    end

    // Derived from state so it drops together with the async reset.
    assign busy = (state != S_IDLE);

`ifdef PWM_COMPL_EN
    // -----------------------------------------------------------------------
    // Complementary output with dead time. raw_q is the plain PWM waveform;
    // every change of it reloads the dead counter, and neither output may be
    // high until the counter has run out. A raw pulse shorter than DEAD_CYC
    // keeps reloading the counter and therefore never appears at all.
    // -----------------------------------------------------------------------
    localparam int unsigned DEAD_W = (DEAD_CYC < 4) ? 2 : $clog2(DEAD_CYC + 1);

    logic              raw_q;
    logic [DEAD_W-1:0] dead_cnt, dead_nxt;
    logic              pwm_out_d;
    logic              pwm_n_d;

    always_comb begin
        dead_nxt = dead_cnt;
        if (pwm_d != raw_q) begin
            dead_nxt = DEAD_W'(DEAD_CYC);
        end else if (dead_cnt != '0) begin
            dead_nxt = dead_cnt - 1'b1;
        end
        pwm_out_d = pwm_d && (dead_nxt == '0);
        pwm_n_d   = !pwm_d && run_nxt && (dead_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_q    <= 1'b0;
            dead_cnt <= '0;
            pwm      <= 1'b0;
            pwm_n    <= 1'b0;
        end else begin
            raw_q    <= pwm_d;
            dead_cnt <= dead_nxt;
            pwm      <= pwm_out_d;
            pwm_n    <= pwm_n_d;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= pwm_d;
        end
    end
`endif

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Downstream consumer of the 3-bit frequency-select counter in the PWM path.
- Converts the frequency code `freq_sel` and a duty word `duty` into a glitch-free PWM waveform, plus a period-start strobe.
- Both inputs are shadow-latched at period boundaries, so button-driven changes never truncate or stretch a running period.
- Sits between the frequency-select and duty controls and the output pin driver.

Parameters:
- BASE_DIV, 16: clk cycles per PWM tick at freq_sel=0; must be ≥1.
- DUTY_W, 4: duty resolution in bits; a period is 2^DUTY_W ticks.
- DEAD_CYC, 2: dead time in clk cycles, used only with PWM_COMPL_EN.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-low reset (asserted when 0).
- en, in, 1: run request, level-sensitive.
- freq_sel, in, 3: frequency code; tick length = BASE_DIV << freq_sel clk cycles.
- duty, in, DUTY_W: high time in ticks per period.
- pwm, out, 1: PWM output, registered.
- period_start, out, 1: one-clk pulse on the first cycle of every period.
- busy, out, 1: high in LOAD, RUN and DRAIN.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; div_cnt=0, pwm_cnt=0, fsel_r=0, duty_r=0.
  - pwm=0, period_start=0, busy=0.
- Prescaler:
  - div_cnt counts 0..(BASE_DIV<<fsel_r)-1; tick is asserted on the terminal count, then div_cnt wraps to 0.
  - div_cnt width is clog2(BASE_DIV*128); no overflow is permitted.
- Period counter:
  - pwm_cnt (DUTY_W bits) increments on each tick and wraps from 2^DUTY_W-1 to 0.
  - Period boundary (pb) = tick while pwm_cnt = max.
- Shadow registers:
  - fsel_r and duty_r load from freq_sel and duty in LOAD and on every pb.
  - Between those points, input changes are ignored.
- FSM:
  - IDLE: counters held at 0, pwm=0. en=1 → LOAD.
  - LOAD (1 cycle): latch the shadow registers, clear the counters → RUN.
  - RUN: normal operation. en=0 → DRAIN. Otherwise stay.
  - DRAIN: the current period completes normally.
    - On pb with en=0 → IDLE.
    - On pb with en=1 → RUN with a normal shadow reload.
    - en re-asserted before pb → RUN immediately, no glitch and no counter disturbance.
- Output timing:
  - pwm is registered. In RUN/DRAIN, pwm=1 exactly during the clk cycles whose pwm_cnt < duty_r.
  - High time = duty_r·(BASE_DIV<<fsel_r) cycles; period = 2^DUTY_W·(BASE_DIV<<fsel_r) cycles.
  - The first period starts on the cycle after LOAD.
  - duty_r=0 → pwm held 0.
  - duty_r=max → high for (2^DUTY_W-1)/2^DUTY_W of the period. 100% duty is not supported.
- period_start: pulses in the cycle after LOAD and in the cycle after each pb, except the pb that exits to IDLE.
- IDLE exit: pwm=0 in the first IDLE cycle.
- freq_sel wrap-around (7→0 from upstream): handled as a normal code change, applied at the next pb.
- Reset mid-period: all state is cleared immediately; no partial period is finished.

Optional Feature:
- Macro PWM_COMPL_EN.
- Defined:
  - Adds output pwm_n (out, 1), the complement of pwm with dead time.
  - After any pwm edge, both pwm and pwm_n are held low for DEAD_CYC clk cycles before the newly active output rises. A 2-bit-or-wider dead counter implements this.
  - A pulse shorter than DEAD_CYC on either side is suppressed entirely.
  - pwm_n=0 in IDLE and during reset.
- Undefined:
  - No pwm_n port, no dead counter.
  - pwm timing exactly as above.

Test Plan:
- Defaults, freq_sel=0, duty=4, en=1:
  - period_start every 256 cycles; pwm high 64 cycles, low 192.
  - First period_start one cycle after LOAD.
- freq_sel=3, duty=8, run 3 periods → period 2048 cycles, pwm high 1024.
- Change duty 4→12 and freq_sel 0→1 mid-period (cycle 100):
  - Current period unchanged (64 high / 256 period).
  - Next period 384 high / 512 period.
- duty=0 → pwm never 1 while period_start continues. duty=15 → high 240 of 256.
- en=0 at cycle 50 of a period:
  - pwm continues until the period ends; busy drops after pb; no period_start at exit.
  - Re-asserting en at cycle 120 of DRAIN → uninterrupted operation.
- rst=0 asynchronously mid-high-phase → pwm, period_start and busy go 0 without waiting for a clk edge. With PWM_COMPL_EN, duty=8, DEAD_CYC=2 → pwm and pwm_n never high together, and there is a 2-cycle gap at each transition.
